// File: rtl/sysid_ext_pkg.sv
// sysid_ext_pkg: shared widths, register map addresses and byte-lane merge helper.
package sysid_ext_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ADDR_SYSTEM_ID  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_HW_VERSION = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_FEATURES   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_SECONDS    = 3'd7;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_ext_if.sv
// sysid_ext_if: Avalon-MM style register bus between a master and sysid_ext.
//
// Handshake: there is no waitrequest. A transfer happens on every rising
// edge where read or write is high; the slave always accepts it. Each read
// produces exactly one response: readdatavalid is high for one cycle, the
// cycle right after the read was sampled, with readdata holding the word.
// Responses come back in request order. readdata holds its last value while
// readdatavalid is low.
interface sysid_ext_if;
  import sysid_ext_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_ext_uptime.sv
// sysid_ext_uptime: free-running 64-bit cycle counter plus a seconds counter
// driven by a prescaler that divides clk by CLK_FREQ_HZ.
module sysid_ext_uptime
  import sysid_ext_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [63:0]       o_uptime,
  output logic [DATA_W-1:0] o_seconds
);

  // Terminal prescaler count; with CLK_FREQ_HZ=1 this is 0, so every cycle ticks.
  localparam logic [31:0] PRESC_TERM = 32'(CLK_FREQ_HZ - 1);

  logic [63:0]       r_uptime;
  logic [31:0]       r_presc;
  logic [DATA_W-1:0] r_seconds;

  // Uptime counts every cycle out of reset; seconds advance on prescaler wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uptime  <= '0;
      r_presc   <= '0;
      r_seconds <= '0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
      if (r_presc == PRESC_TERM) begin
        r_presc   <= '0;
        r_seconds <= r_seconds + 1'b1;
      end else begin
        r_presc <= r_presc + 32'd1;
      end
    end
  end

  assign o_uptime  = r_uptime;
  assign o_seconds = r_seconds;

endmodule

// File: rtl/sysid_ext.sv
// sysid_ext: system identification register block. Four build-time constant
// words, a scratch register, a 64-bit uptime readable as LO + shadowed HI,
// and a seconds counter. Fixed read latency of one cycle.
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter logic [31:0] HW_VERSION  = 32'h0001_0000,
  parameter logic [31:0] FEATURES    = 32'h0,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  sysid_ext_if.slave  bus
);

  logic [63:0]       w_uptime;
  logic [DATA_W-1:0] w_seconds;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_scratch;
  logic              w_rd_uptime_lo;

  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_readdata;
  logic              r_readdatavalid;

  sysid_ext_uptime #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_uptime (
    .clk       (clk),
    .reset     (reset),
    .o_uptime  (w_uptime),
    .o_seconds (w_seconds)
  );

  assign w_wr_scratch   = bus.write && (bus.address == ADDR_SCRATCH);
  assign w_rd_uptime_lo = bus.read && (bus.address == ADDR_UPTIME_LO);

  // Read mux over current register values, so a same-cycle write is not visible.
  always_comb begin
    w_rd_data = '0;
    case (bus.address)
      ADDR_SYSTEM_ID:  w_rd_data = SYSTEM_ID;
      ADDR_TIMESTAMP:  w_rd_data = TIMESTAMP;
      ADDR_HW_VERSION: w_rd_data = HW_VERSION;
      ADDR_FEATURES:   w_rd_data = FEATURES;
      ADDR_SCRATCH:    w_rd_data = r_scratch;
      ADDR_UPTIME_LO:  w_rd_data = w_uptime[31:0];
      ADDR_UPTIME_HI:  w_rd_data = r_shadow;
      ADDR_SECONDS:    w_rd_data = w_seconds;
      default:         w_rd_data = '0;
    endcase
  end

  // Scratch writes with byte lanes, HI shadow capture, and the response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch       <= '0;
      r_shadow        <= '0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      if (w_wr_scratch) begin
        r_scratch <= merge_bytes(r_scratch, bus.writedata, bus.byteenable);
      end
      if (w_rd_uptime_lo) begin
        r_shadow <= w_uptime[63:32];
      end
      r_readdatavalid <= bus.read;
      if (bus.read) begin
        r_readdata <= w_rd_data;
      end
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_ext.sv
// tb_sysid_ext: directed bench for sysid_ext with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sysid_ext;
  import sysid_ext_pkg::*;

  localparam logic [31:0] P_SYSTEM_ID  = 32'h3573_E988;
  localparam logic [31:0] P_TIMESTAMP  = 32'h4E0C_7F26;
  localparam logic [31:0] P_HW_VERSION = 32'h0001_0000;
  localparam logic [31:0] P_FEATURES   = 32'h0000_00A5;

  logic clk = 1'b0;
  logic reset;
  logic reset1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sysid_ext_if bus ();
  sysid_ext_if bus1 ();

  sysid_ext #(
    .SYSTEM_ID   (P_SYSTEM_ID),
    .TIMESTAMP   (P_TIMESTAMP),
    .HW_VERSION  (P_HW_VERSION),
    .FEATURES    (P_FEATURES),
    .CLK_FREQ_HZ (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sysid_ext #(
    .CLK_FREQ_HZ (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle on dut; afterwards the response of this cycle is visible.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = wd;
    bus.byteenable = be;
    step();
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic bus1_read(input logic [2:0] a);
    bus1.read    = 1'b1;
    bus1.address = a;
    step();
    bus1.read = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata got %h exp %h", bus.readdata, 32'h0);
    end
    n_cmp++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0", bus.readdatavalid);
    end
    // Read and scratch write while reset is high must be ignored.
    bus_cycle(1'b1, 1'b1, ADDR_SCRATCH, 32'hFFFF_FFFF, 4'hF);
    n_cmp++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_read_ignored valid got %b exp 0", bus.readdatavalid);
    end
    reset = 1'b0;  // cycle 0 out of reset starts now
  endtask

  task automatic test_seconds();
    for (int k = 0; k < 12; k++) begin
      bus_cycle(1'b1, 1'b0, ADDR_SECONDS, 32'h0, 4'h0);
      n_cmp++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== 32'(k / 4)) begin
        n_fail++;
        $display("FAIL seconds_c%0d got v=%b d=%h exp v=1 d=%h", k, bus.readdatavalid,
                 bus.readdata, 32'(k / 4));
      end
    end
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 4'h0);  // cycle 12
    n_cmp++;
    if (bus.readdata !== 32'd12) begin
      n_fail++; $display("FAIL uptime_first got %h exp %h", bus.readdata, 32'd12);
    end
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_HI, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL uptime_hi_first got %h exp %h", bus.readdata, 32'h0);
    end
    bus_cycle(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL scratch_reset_write got %h exp %h", bus.readdata, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    exp_d[0] = P_SYSTEM_ID; exp_d[1] = P_TIMESTAMP;
    exp_d[2] = P_HW_VERSION; exp_d[3] = P_FEATURES;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b1, 1'b0, 3'(i), 32'h0, 4'h0);
      n_cmp++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== exp_d[i]) begin
        n_fail++;
        $display("FAIL b2b_w%0d got v=%b d=%h exp v=1 d=%h", i, bus.readdatavalid,
                 bus.readdata, exp_d[i]);
      end
    end
    step();
    n_cmp++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== P_FEATURES) begin
      n_fail++;
      $display("FAIL idle_hold got v=%b d=%h exp v=0 d=%h", bus.readdatavalid,
               bus.readdata, P_FEATURES);
    end
  endtask

  task automatic test_scratch();
    bus_cycle(1'b0, 1'b1, ADDR_SCRATCH, 32'hDEAD_BEEF, 4'hF);
    n_cmp++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL write_no_resp valid got %b exp 0", bus.readdatavalid);
    end
    bus_cycle(1'b0, 1'b1, ADDR_SCRATCH, 32'h1234_5678, 4'b0101);
    bus_cycle(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'hDE34_BE78) begin
      n_fail++; $display("FAIL scratch_be got %h exp %h", bus.readdata, 32'hDE34_BE78);
    end
    bus_cycle(1'b0, 1'b1, ADDR_SYSTEM_ID, 32'hFFFF_FFFF, 4'hF);
    bus_cycle(1'b1, 1'b0, ADDR_SYSTEM_ID, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== P_SYSTEM_ID) begin
      n_fail++; $display("FAIL ro_write got %h exp %h", bus.readdata, P_SYSTEM_ID);
    end
    bus_cycle(1'b0, 1'b1, ADDR_UPTIME_LO, 32'h0, 4'hF);
    bus_cycle(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'hDE34_BE78) begin
      n_fail++; $display("FAIL scratch_other_write got %h exp %h", bus.readdata, 32'hDE34_BE78);
    end
  endtask

  task automatic test_uptime_shadow();
    force dut.u_uptime.r_uptime = 64'h0000_0000_FFFF_FFFE;
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL uptime_lo got %h exp %h", bus.readdata, 32'hFFFF_FFFE);
    end
    // Live counter carries into the upper word; the shadow must not follow.
    force dut.u_uptime.r_uptime = 64'h0000_0001_0000_0003;
    repeat (4) step();
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_HI, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL uptime_hi_shadow got %h exp %h", bus.readdata, 32'h0);
    end
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'h3) begin
      n_fail++; $display("FAIL uptime_lo2 got %h exp %h", bus.readdata, 32'h3);
    end
    bus_cycle(1'b1, 1'b0, ADDR_UPTIME_HI, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'h1) begin
      n_fail++; $display("FAIL uptime_hi_capture got %h exp %h", bus.readdata, 32'h1);
    end
    release dut.u_uptime.r_uptime;
  endtask

  task automatic test_seconds_wrap();
    logic seen_zero;
    int   bad;
    seen_zero = 1'b0;
    bad       = 0;
    force dut.u_uptime.r_seconds = 32'hFFFF_FFFF;
    bus_cycle(1'b1, 1'b0, ADDR_SECONDS, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL seconds_max got %h exp %h", bus.readdata, 32'hFFFF_FFFF);
    end
    release dut.u_uptime.r_seconds;
    // Within one prescaler period (4 cycles) the counter must wrap to 0.
    for (int i = 0; i < 6; i++) begin
      bus_cycle(1'b1, 1'b0, ADDR_SECONDS, 32'h0, 4'h0);
      if (!seen_zero) begin
        if (bus.readdata === 32'h0) seen_zero = 1'b1;
        else if (bus.readdata !== 32'hFFFF_FFFF) bad++;
      end
    end
    n_cmp++;
    if (!seen_zero || bad != 0) begin
      n_fail++;
      $display("FAIL seconds_wrap got seen_zero=%b bad=%0d exp seen_zero=1 bad=0", seen_zero, bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  addr_seq [4];
    logic [31:0] exp_seq  [4];
    bus_cycle(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, 4'h0);
    reset = 1'b1;
    step();
    n_cmp++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid got v=%b d=%h exp v=0 d=0", bus.readdatavalid, bus.readdata);
    end
    bus_cycle(1'b1, 1'b0, ADDR_SYSTEM_ID, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_read_cancel valid got %b exp 0", bus.readdatavalid);
    end
    reset = 1'b0;
    addr_seq[0] = ADDR_SCRATCH;   exp_seq[0] = 32'h0;
    addr_seq[1] = ADDR_UPTIME_HI; exp_seq[1] = 32'h0;
    addr_seq[2] = ADDR_UPTIME_LO; exp_seq[2] = 32'h2;
    addr_seq[3] = ADDR_SECONDS;   exp_seq[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b1, 1'b0, addr_seq[i], 32'h0, 4'h0);
      n_cmp++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL post_reset_a%0d got v=%b d=%h exp v=1 d=%h", addr_seq[i],
                 bus.readdatavalid, bus.readdata, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rw_collision();
    bus_cycle(1'b1, 1'b1, ADDR_SCRATCH, 32'hA5A5_A5A5, 4'hF);
    n_cmp++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rw_old got v=%b d=%h exp v=1 d=0", bus.readdatavalid, bus.readdata);
    end
    bus_cycle(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, 4'h0);
    n_cmp++;
    if (bus.readdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL rw_new got %h exp %h", bus.readdata, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_freq1();
    reset1 = 1'b1;
    repeat (2) step();
    reset1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus1_read(ADDR_SECONDS);
      n_cmp++;
      if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'(k)) begin
        n_fail++;
        $display("FAIL freq1_sec_c%0d got v=%b d=%h exp v=1 d=%h", k, bus1.readdatavalid,
                 bus1.readdata, 32'(k));
      end
    end
    bus1_read(ADDR_UPTIME_LO);
    n_cmp++;
    if (bus1.readdata !== 32'd5) begin
      n_fail++; $display("FAIL freq1_uptime got %h exp %h", bus1.readdata, 32'd5);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    reset1 = 1'b1;
    bus.read = 1'b0;  bus.write = 1'b0;  bus.address = '0;
    bus.writedata = '0;  bus.byteenable = '0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
    bus1.writedata = '0; bus1.byteenable = '0;
    #1;
    test_reset();
    test_seconds();
    test_back_to_back();
    test_scratch();
    test_uptime_shadow();
    test_seconds_wrap();
    test_reset_mid();
    test_rw_collision();
    test_freq1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_ext.md
SYSID_EXT -- requirements
Module: sysid_ext

Interface
REQ-001 Parameter SYSTEM_ID, 32'h0, system identifier returned at word 0.
REQ-002 Parameter TIMESTAMP, 32'h0, build timestamp (Unix seconds) returned at word 1.
REQ-003 Parameter HW_VERSION, 32'h0001_0000, major[31:16]/minor[15:0] returned at word 2.
REQ-004 Parameter FEATURES, 32'h0, feature bitmask returned at word 3.
REQ-005 Parameter CLK_FREQ_HZ, 50_000_000, clk cycles per second; legal range 1..2^32-1.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  3  Avalon-MM word address.
REQ-009 read  in  1  read strobe, one transfer per asserted cycle.
REQ-010 write  in  1  write strobe, one transfer per asserted cycle.
REQ-011 writedata  in  32  write data.
REQ-012 byteenable  in  4  byte lanes for writes; bit n enables writedata[8n+7:8n].
REQ-013 readdata  out  32  registered read data.
REQ-014 readdatavalid  out  1  high exactly one cycle when readdata holds a response.

Function
REQ-015 Map: 0 SYSTEM_ID RO, 1 TIMESTAMP RO, 2 HW_VERSION RO, 3 FEATURES RO, 4 SCRATCH RW, 5 UPTIME_LO RO, 6 UPTIME_HI RO (shadow), 7 SECONDS RO; words 0/1 keep previous-generation sysid meaning.
REQ-016 No waitrequest; every read and write accepted in the cycle presented.
REQ-017 Read latency fixed at 1: read at edge N gives readdatavalid=1 and readdata at edge N+1.
REQ-018 Back-to-back reads every cycle supported; readdatavalid stays high, one response per read, in order.
REQ-019 readdata holds its last value when readdatavalid is low.
REQ-020 Writes to SCRATCH update only enabled byte lanes; writes to any other address are ignored with no side effect.
REQ-021 Uptime: 64-bit counter increments by 1 every cycle out of reset, wraps 2^64-1 -> 0 silently.
REQ-022 Read of UPTIME_LO returns counter[31:0] as sampled at the read cycle and copies counter[63:32] from the same cycle into the UPTIME_HI shadow.
REQ-023 Read of UPTIME_HI returns the shadow; shadow changes only on an UPTIME_LO read or reset.
REQ-024 Seconds: prescaler counts 0..CLK_FREQ_HZ-1; on terminal count it returns to 0 and SECONDS increments by 1; SECONDS wraps 2^32-1 -> 0.
REQ-025 CLK_FREQ_HZ=1: SECONDS increments every cycle.
REQ-026 read and write asserted together (illegal on bus, defined here): write takes effect; read returns pre-write value.
REQ-027 Reset asserted mid-transaction: pending response cancelled; readdatavalid=0 in the cycle after reset is sampled.

Reset
REQ-028 During reset: readdata=0, readdatavalid=0, SCRATCH=0, uptime=0, shadow=0, prescaler=0, SECONDS=0.
REQ-029 Reads or writes presented while reset is high are ignored.
REQ-030 First uptime increment occurs on the first edge with reset low.

Structure
REQ-031 Package sysid_ext_pkg holds address constants (ADDR_SYSTEM_ID..ADDR_SECONDS), address width 3, data width 32.
REQ-032 Sub-module sysid_ext_uptime holds the 64-bit counter, prescaler and SECONDS counter, parameterised by CLK_FREQ_HZ.
REQ-033 Top-level holds decode, SCRATCH, shadow and read pipeline register.

Verification
REQ-034 SYSTEM_ID=32'h3573_E988, TIMESTAMP=32'h4E0C_7F26; read addr 0 then 1 back-to-back -> readdatavalid two consecutive cycles, data 32'h3573_E988 then 32'h4E0C_7F26.
REQ-035 Write SCRATCH 32'hDEAD_BEEF be=4'hF, then 32'h1234_5678 be=4'b0101, read addr 4 -> 32'hDE34_BE78; write addr 0 -> addr 0 still reads SYSTEM_ID.
REQ-036 Force uptime to 64'h0000_0000_FFFF_FFFE; read LO at that cycle -> LO=32'hFFFF_FFFE; read HI 5 cycles later -> 32'h0 (shadow, despite live carry to 1).
REQ-037 CLK_FREQ_HZ=4, release reset, read SECONDS every cycle -> value 0 for cycles 0-3, increments every 4 cycles; force SECONDS=32'hFFFF_FFFF -> wraps to 0.
REQ-038 Read issued, reset asserted next edge -> no readdatavalid; all registers read back reset values after release.
REQ-039 Simultaneous read+write to SCRATCH (old 32'h0, new 32'hA5A5_A5A5) -> response 32'h0; next read -> 32'hA5A5_A5A5.
